distribute_1x2_credit_ctrl: RTL and testbench

//  Credit-based scheduler that sequences one 1x2 distribute switch.
//  - Accepts packets (data + 2-bit destination mask) over a valid/ready handshake.
//  - Tracks downstream buffer credits per branch.
//  - Drives the switch's en/valid/cmd/data so that no branch is ever sent data without a credit.
//  - Sits directly upstream of each distribute switch node in the distribution network.

---
 rtl/distribute_1x2_credit_ctrl_pkg.sv | 27 ++
 rtl/distribute_1x2_credit_ctrl_counter.sv | 39 +++
 rtl/distribute_1x2_credit_ctrl.sv | 115 +++++++++++
 tb/tb_distribute_1x2_credit_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/distribute_1x2_credit_ctrl_pkg.sv
// Shared types for the 1x2 distribute credit controller: switch commands, FSM states and grant rule.
// PARTIAL_MULTICAST_EN selects split (per-branch) multicast instead of atomic multicast.
package distribute_pkg;

  localparam logic [1:0] CMD_NA   = 2'b00;
  localparam logic [1:0] CMD_LOW  = 2'b01;
  localparam logic [1:0] CMD_HIGH = 2'b10;
  localparam logic [1:0] CMD_DUP  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Which pending branches may be issued this cycle given per-branch credit availability.
  function automatic logic [1:0] grant_f(input logic [1:0] pending, input logic [1:0] avail);
`ifdef PARTIAL_MULTICAST_EN
    return pending & avail;
`else
    if (pending == CMD_DUP) begin
      return (avail == 2'b11) ? CMD_DUP : CMD_NA;
    end
    return pending & avail;
`endif
  endfunction

endpackage

// File: rtl/distribute_1x2_credit_ctrl_counter.sv
// Saturating per-branch credit counter; starts full at MAX_CREDIT and flags returns that would overflow.
module distribute_credit_counter #(
  parameter int CREDIT_WIDTH = 4,
  parameter int MAX_CREDIT   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_consume,
  input  logic                    i_return,
  output logic [CREDIT_WIDTH-1:0] o_cnt,
  output logic                    o_avail,
  output logic                    o_overflow
);

  localparam logic [CREDIT_WIDTH-1:0] MAX_CNT = CREDIT_WIDTH'(MAX_CREDIT);
  localparam logic [CREDIT_WIDTH-1:0] ONE     = CREDIT_WIDTH'(1);

  logic [CREDIT_WIDTH-1:0] r_cnt;
  logic                    w_dec;
  logic                    w_inc;

  // A simultaneous consume and return cancel out and leave the count untouched.
  assign o_avail    = (r_cnt != '0);
  assign w_dec      = i_consume & ~i_return & o_avail;
  assign w_inc      = i_return & ~i_consume & (r_cnt != MAX_CNT);
  assign o_overflow = i_return & ~i_consume & (r_cnt == MAX_CNT);
  assign o_cnt      = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= MAX_CNT;
    end else if (w_dec) begin
      r_cnt <= r_cnt - ONE;
    end else if (w_inc) begin
      r_cnt <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/distribute_1x2_credit_ctrl.sv
// Credit-based scheduler feeding one 1x2 distribute switch; never issues to a branch without a credit.
// Build option: define PARTIAL_MULTICAST_EN to let a dest=11 packet issue its branches in separate cycles.
module distribute_1x2_credit_ctrl
  import distribute_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = 2,
  parameter int CREDIT_WIDTH  = 4,
  parameter int MAX_CREDIT    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [DATA_WIDTH-1:0]     i_data_bus,
  input  logic [1:0]                i_dest,
  input  logic [1:0]                i_credit_return,
  output logic                      o_sw_en,
  output logic                      o_sw_valid,
  output logic [COMMAND_WIDTH-1:0]  o_sw_cmd,
  output logic [DATA_WIDTH-1:0]     o_sw_data_bus,
  output logic [2*CREDIT_WIDTH-1:0] o_credit_cnt,
  output logic                      o_credit_err
);

  state_e                  r_state;
  logic [1:0]              r_pending;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_ready;
  logic                    r_credit_err;

  logic                    w_accept;
  logic [1:0]              w_avail;
  logic [1:0]              w_overflow;
  logic [1:0]              w_grant;
  logic [1:0]              w_pending_nxt;
  logic [CREDIT_WIDTH-1:0] w_cnt_lo;
  logic [CREDIT_WIDTH-1:0] w_cnt_hi;

  // Handshake: a packet transfers on a cycle where i_valid and i_ready are both high;
  // i_ready is only high while nothing is held, so at most one packet is ever in flight.
  assign w_accept      = i_valid & r_ready;
  assign w_grant       = (r_state == ST_HOLD) ? grant_f(r_pending, w_avail) : CMD_NA;
  assign w_pending_nxt = r_pending & ~w_grant;

  distribute_credit_counter #(
    .CREDIT_WIDTH (CREDIT_WIDTH),
    .MAX_CREDIT   (MAX_CREDIT)
  ) u_cnt_lo (
    .clk        (clk),
    .rst        (rst),
    .i_consume  (w_grant[0]),
    .i_return   (i_credit_return[0]),
    .o_cnt      (w_cnt_lo),
    .o_avail    (w_avail[0]),
    .o_overflow (w_overflow[0])
  );

  distribute_credit_counter #(
    .CREDIT_WIDTH (CREDIT_WIDTH),
    .MAX_CREDIT   (MAX_CREDIT)
  ) u_cnt_hi (
    .clk        (clk),
    .rst        (rst),
    .i_consume  (w_grant[1]),
    .i_return   (i_credit_return[1]),
    .o_cnt      (w_cnt_hi),
    .o_avail    (w_avail[1]),
    .o_overflow (w_overflow[1])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pending    <= 2'b00;
      r_data       <= '0;
      r_ready      <= 1'b0;
      r_credit_err <= 1'b0;
    end else begin
      r_credit_err <= r_credit_err | (|w_overflow);
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          // A dest=00 packet is consumed and dropped without leaving IDLE.
          if (w_accept && (i_dest != 2'b00)) begin
            r_data    <= i_data_bus;
            r_pending <= i_dest;
            r_state   <= ST_HOLD;
            r_ready   <= 1'b0;
          end
        end
        ST_HOLD: begin
          r_pending <= w_pending_nxt;
          if (w_pending_nxt == 2'b00) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Switch outputs decode registered state only; all-zero whenever nothing is issued.
  assign i_ready       = r_ready;
  assign o_sw_en       = |w_grant;
  assign o_sw_valid    = |w_grant;
  assign o_sw_cmd      = COMMAND_WIDTH'(w_grant);
  assign o_sw_data_bus = (|w_grant) ? r_data : '0;
  assign o_credit_cnt  = {w_cnt_hi, w_cnt_lo};
  assign o_credit_err  = r_credit_err;

endmodule

// File: tb/tb_distribute_1x2_credit_ctrl.sv
// Scoreboard bench for distribute_1x2_credit_ctrl: directed scenarios followed by random traffic.
// Honours PARTIAL_MULTICAST_EN in its reference grant rule.
module tb_distribute_1x2_credit_ctrl;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int MAXC = 8;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_valid;
  logic            i_ready;
  logic [DW-1:0]   i_data_bus;
  logic [1:0]      i_dest;
  logic [1:0]      i_credit_return;
  logic            o_sw_en;
  logic            o_sw_valid;
  logic [1:0]      o_sw_cmd;
  logic [DW-1:0]   o_sw_data_bus;
  logic [2*CW-1:0] o_credit_cnt;
  logic            o_credit_err;

  always #5 clk = ~clk;

  distribute_1x2_credit_ctrl #(
    .DATA_WIDTH    (DW),
    .COMMAND_WIDTH (2),
    .CREDIT_WIDTH  (CW),
    .MAX_CREDIT    (MAXC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .i_ready         (i_ready),
    .i_data_bus      (i_data_bus),
    .i_dest          (i_dest),
    .i_credit_return (i_credit_return),
    .o_sw_en         (o_sw_en),
    .o_sw_valid      (o_sw_valid),
    .o_sw_cmd        (o_sw_cmd),
    .o_sw_data_bus   (o_sw_data_bus),
    .o_credit_cnt    (o_credit_cnt),
    .o_credit_err    (o_credit_err)
  );

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  logic [DW+1:0] exp_q[$];        // {remaining dest mask, data} of accepted packets
  int            m_cnt[2]  = '{MAXC, MAXC};
  logic          m_err     = 1'b0;
  logic          just_reset = 1'b0;
  logic          rand_ret  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference rule: a packet goes to every wanted branch at once, and only if each has a credit
  // (split build: whatever wanted branches have credits go now, the rest later).
  function automatic logic [1:0] model_grant(input logic [1:0] want);
    logic [1:0] have;
    have = {m_cnt[1] > 0, m_cnt[0] > 0};
`ifdef PARTIAL_MULTICAST_EN
    return want & have;
`else
    return ((want & have) == want) ? want : 2'b00;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [1:0]    want;
    logic [1:0]    issue;
    logic [DW-1:0] edata;
    logic [DW+1:0] head;
    logic          exp_ready;
    cyc++;
    if (rst) begin
      m_cnt      = '{MAXC, MAXC};
      m_err      = 1'b0;
      exp_q.delete();
      just_reset = 1'b1;
    end else begin
      want  = 2'b00;
      edata = '0;
      head  = '0;
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        want = head[DW+1:DW];
      end
      issue = model_grant(want);
      if (issue != 2'b00) edata = head[DW-1:0];
      exp_ready = (exp_q.size() == 0) && !just_reset;

      check("i_ready",       i_ready,       exp_ready);
      check("o_sw_valid",    o_sw_valid,    issue != 2'b00);
      check("o_sw_en",       o_sw_en,       issue != 2'b00);
      check("o_sw_cmd",      o_sw_cmd,      issue);
      check("o_sw_data_bus", o_sw_data_bus, edata);
      check("o_credit_cnt",  o_credit_cnt,  {CW'(m_cnt[1]), CW'(m_cnt[0])});
      check("o_credit_err",  o_credit_err,  m_err);

      for (int b = 0; b < 2; b++) begin
        if (issue[b] && !i_credit_return[b]) begin
          m_cnt[b] = m_cnt[b] - 1;
        end else if (i_credit_return[b] && !issue[b]) begin
          if (m_cnt[b] == MAXC) m_err = 1'b1;
          else m_cnt[b] = m_cnt[b] + 1;
        end
      end

      if (issue != 2'b00) begin
        head[DW+1:DW] = want & ~issue;
        if (head[DW+1:DW] == 2'b00) void'(exp_q.pop_front());
        else exp_q[0] = head;
      end
      just_reset = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ret();
    if (rand_ret) begin
      i_credit_return = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
    end else begin
      i_credit_return = 2'b00;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive_ret();
      tick();
    end
    i_credit_return = 2'b00;
  endtask

  task automatic ret_pulse(input logic [1:0] mask);
    i_credit_return = mask;
    tick();
    i_credit_return = 2'b00;
  endtask

  task automatic do_reset(input int n);
    i_valid = 1'b0;
    rst     = 1'b1;
    repeat (n) tick();
    rst     = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] d, input logic [DW-1:0] x);
    int n;
    bit done;
    n          = 0;
    done       = 1'b0;
    i_valid    = 1'b1;
    i_dest     = d;
    i_data_bus = x;
    while (!done) begin
      drive_ret();
      @(negedge clk);
      #1;
      if (i_ready === 1'b1) begin
        if (d != 2'b00) exp_q.push_back({d, x});
        done = 1'b1;
      end else if (++n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=i_ready_low expected=i_ready_high cycle=%0d", cyc);
        done = 1'b1;
      end
      tick();
    end
    i_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    i_valid         = 1'b0;
    i_dest          = 2'b00;
    i_data_bus      = '0;
    i_credit_return = 2'b00;
    do_reset(3);

    // Single low-branch packet: issue one cycle after accept, low count 8 -> 7.
    send_pkt(2'b01, 32'hA5A5_A5A5);
    idle(3);

    // Exhaust high credits; ninth packet waits until one credit returns.
    do_reset(2);
    for (int i = 0; i < 8; i++) send_pkt(2'b10, $urandom);
    send_pkt(2'b10, 32'h9999_0009);
    idle(4);
    ret_pulse(2'b10);
    idle(3);

    // Multicast with low=0, high=3.
    do_reset(2);
    for (int i = 0; i < 8; i++) send_pkt(2'b01, $urandom);
    for (int i = 0; i < 5; i++) send_pkt(2'b10, $urandom);
    send_pkt(2'b11, 32'hD00D_1111);
    idle(4);
    ret_pulse(2'b01);
    idle(3);

    // Same-cycle consume and return at low=1, then a return into a full counter.
    do_reset(2);
    for (int i = 0; i < 7; i++) send_pkt(2'b01, $urandom);
    send_pkt(2'b01, 32'h0000_0C0C);
    ret_pulse(2'b01);
    idle(2);
    do_reset(2);
    ret_pulse(2'b01);
    idle(3);

    // Reset while a multicast is held, then a dropped dest=00 packet.
    do_reset(2);
    for (int i = 0; i < 8; i++) send_pkt(2'b01, $urandom);
    send_pkt(2'b11, 32'hBEEF_0011);
    idle(2);
    do_reset(1);
    send_pkt(2'b00, 32'h0BAD_0000);
    idle(3);

    // Random traffic with random credit returns.
    do_reset(2);
    rand_ret = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send_pkt(2'($urandom_range(0, 3)), $urandom);
      idle($urandom_range(0, 2));
    end
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      drive_ret();
      tick();
      n++;
    end
    rand_ret = 1'b0;
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d_outstanding expected=0_outstanding", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
